// File: rtl/generic_counter.sv
// generic_counter: free-running modulo counter with a one-cycle terminal-count
// strobe. Counts enabled CLK cycles 0..COUNTER_MAX, wraps to 0 and pulses
// TRIG_OUT once per wrap. RESET is asynchronous and active-low.
//
// Build option: define GENERIC_COUNTER_COMB_TRIG_EN to make TRIG_OUT a
// combinational look-ahead strobe (ENABLE_IN & COUNT==COUNTER_MAX & RESET),
// high in the cycle before the wrap edge. Without it TRIG_OUT is registered,
// glitch-free and safe to use as a downstream clock. COUNT is identical in
// both builds.
module generic_counter #(
  parameter int COUNTER_WIDTH = 4,
  parameter int COUNTER_MAX   = 9
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     ENABLE_IN,
  output logic [COUNTER_WIDTH-1:0] COUNT,
  output logic                     TRIG_OUT
);

  // Reject parameterisations that cannot describe a valid counter.
  generate
    if (COUNTER_WIDTH < 1) begin : g_bad_width
      $error("generic_counter: COUNTER_WIDTH must be at least 1");
    end
    if ((COUNTER_MAX < 0) ||
        (longint'(COUNTER_MAX) > ((longint'(1) << COUNTER_WIDTH) - 1))) begin : g_bad_max
      $error("generic_counter: COUNTER_MAX does not fit in COUNTER_WIDTH bits");
    end
  endgenerate

  localparam logic [COUNTER_WIDTH-1:0] MAX_VAL = COUNTER_WIDTH'(COUNTER_MAX);
  localparam logic [COUNTER_WIDTH-1:0] ONE     = COUNTER_WIDTH'(1);

  // Only an exact match is terminal; an out-of-range count just keeps
  // incrementing and wraps modulo 2^COUNTER_WIDTH.
  logic at_max;
  assign at_max = (COUNT == MAX_VAL);

  // Count register: advance on enabled edges, wrap to zero at the terminal count.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      COUNT <= '0;
    end else if (ENABLE_IN) begin
      COUNT <= at_max ? '0 : COUNT + ONE;
    end
  end

`ifdef GENERIC_COUNTER_COMB_TRIG_EN
  // Look-ahead strobe: lets a cascaded enable advance on the same edge as the wrap.
  always_comb begin
    TRIG_OUT = ENABLE_IN & at_max & RESET;
  end
`else
  logic trig_q;

  // Registered strobe: high for the single cycle after the wrapping edge.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      trig_q <= 1'b0;
    end else begin
      trig_q <= ENABLE_IN & at_max;
    end
  end

  assign TRIG_OUT = trig_q;
`endif

endmodule

// File: tb/tb_generic_counter.sv
// Self-checking bench for generic_counter: a vector table for the default
// instance plus hand-written sequences for reset, gating, boundaries and cascade.
module tb_generic_counter;

  logic        CLK;
  logic        RESET;
  logic        en_main, en_g, en_big, en_c;
  logic [3:0]  cnt_main, cnt_m3, cnt_m0, cnt_a, cnt_b;
  logic [11:0] cnt_big;
  logic        trig_main, trig_m3, trig_m0, trig_big, trig_a, trig_b;

  int n_vec = 0;
  int n_err = 0;

  generic_counter #(.COUNTER_WIDTH(4), .COUNTER_MAX(9)) dut_main (
    .CLK(CLK), .RESET(RESET), .ENABLE_IN(en_main), .COUNT(cnt_main), .TRIG_OUT(trig_main));
  generic_counter #(.COUNTER_WIDTH(4), .COUNTER_MAX(3)) dut_m3 (
    .CLK(CLK), .RESET(RESET), .ENABLE_IN(en_g), .COUNT(cnt_m3), .TRIG_OUT(trig_m3));
  generic_counter #(.COUNTER_WIDTH(4), .COUNTER_MAX(0)) dut_m0 (
    .CLK(CLK), .RESET(RESET), .ENABLE_IN(en_g), .COUNT(cnt_m0), .TRIG_OUT(trig_m0));
  generic_counter #(.COUNTER_WIDTH(12), .COUNTER_MAX(4094)) dut_big (
    .CLK(CLK), .RESET(RESET), .ENABLE_IN(en_big), .COUNT(cnt_big), .TRIG_OUT(trig_big));
  generic_counter #(.COUNTER_WIDTH(4), .COUNTER_MAX(3)) dut_a (
    .CLK(CLK), .RESET(RESET), .ENABLE_IN(en_c), .COUNT(cnt_a), .TRIG_OUT(trig_a));
  generic_counter #(.COUNTER_WIDTH(4), .COUNTER_MAX(2)) dut_b (
    .CLK(CLK), .RESET(RESET), .ENABLE_IN(trig_a), .COUNT(cnt_b), .TRIG_OUT(trig_b));

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    logic rst;
    logic en;
    int   cnt;
    logic trig;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic rst, input logic en, input int cnt, input logic trig);
    vec_t v;
    v.rst = rst; v.en = en; v.cnt = cnt; v.trig = trig;
    vq.push_back(v);
  endtask

  // Sampled 1 time unit after the rising edge, with inputs still unchanged.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected TRIG_OUT after an edge: the registered build reports whether the
  // edge wrapped; the look-ahead build reports current enable & at-max & reset.
  function automatic logic exp_trig(input logic wrapped, input logic en,
                                    input logic now_max, input logic rst);
`ifdef GENERIC_COUNTER_COMB_TRIG_EN
    return en & now_max & rst;
`else
    return wrapped & rst;
`endif
  endfunction

  task automatic do_reset();
    RESET = 1'b0;
    step();
    RESET = 1'b1;
  endtask

  initial begin
    int m3, pulses, last, expc;
    logic wr, saw_4094, saw_4095;

    RESET = 1'b0;
    en_main = 1'b0; en_g = 1'b0; en_big = 1'b0; en_c = 1'b0;

    // Main instance, COUNTER_MAX = 9.
    for (int i = 0; i < 3; i++) add(1'b0, 1'b1, 0, 1'b0);
    for (int i = 1; i <= 9; i++) add(1'b1, 1'b1, i, 1'b0);
    add(1'b1, 1'b1, 0, 1'b1);
    add(1'b1, 1'b0, 0, 1'b0);
    for (int i = 1; i <= 9; i++) add(1'b1, 1'b1, i, 1'b0);
    add(1'b1, 1'b0, 9, 1'b0);
    add(1'b1, 1'b0, 9, 1'b0);
    add(1'b1, 1'b1, 0, 1'b1);
    add(1'b1, 1'b1, 1, 1'b0);

    foreach (vq[i]) begin
      RESET   = vq[i].rst;
      en_main = vq[i].en;
      step();
      check($sformatf("vec%0d_count", i), int'(cnt_main), vq[i].cnt);
      check($sformatf("vec%0d_trig", i), int'(trig_main),
            int'(exp_trig(vq[i].trig, vq[i].en, vq[i].cnt == 9, vq[i].rst)));
    end

    // Asynchronous reset mid-count at COUNT=5.
    en_main = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check("pre_reset_count", int'(cnt_main), 5);
    #2;
    RESET = 1'b0;
    #1;
    check("async_reset_count", int'(cnt_main), 0);
    check("async_reset_trig", int'(trig_main), 0);
    step();
    check("held_reset_count", int'(cnt_main), 0);
    RESET = 1'b1;
    step();
    check("reset_exit_count", int'(cnt_main), 1);
    check("reset_exit_trig", int'(trig_main), 0);

    // Reset kills an in-flight strobe.
    for (int i = 0; i < 9; i++) step();
    check("wrap_count", int'(cnt_main), 0);
    check("wrap_trig", int'(trig_main), int'(exp_trig(1'b1, 1'b1, 1'b0, 1'b1)));
    #2;
    RESET = 1'b0;
    #1;
    check("inflight_reset_trig", int'(trig_main), 0);
    check("inflight_reset_count", int'(cnt_main), 0);
    step();
    RESET = 1'b1;

    // 30 enabled cycles: three wraps ten cycles apart.
    en_main = 1'b0;
    do_reset();
    en_main = 1'b1;
    pulses = 0;
    for (int i = 1; i <= 30; i++) begin
      step();
      expc = i % 10;
      check($sformatf("run30_count%0d", i), int'(cnt_main), expc);
      check($sformatf("run30_trig%0d", i), int'(trig_main),
            int'(exp_trig(expc == 0, 1'b1, expc == 9, 1'b1)));
      if (trig_main) pulses++;
    end
    check("run30_pulses", pulses, 3);
    en_main = 1'b0;

    // Enable toggled every cycle: MAX=3 and MAX=0 instances.
    do_reset();
    m3 = 0;
    pulses = 0;
    for (int i = 0; i < 32; i++) begin
      en_g = (i % 2 == 0);
      wr = 1'b0;
      if (en_g) begin
        wr = (m3 == 3);
        m3 = wr ? 0 : m3 + 1;
      end
      step();
      check($sformatf("gate_m3_count%0d", i), int'(cnt_m3), m3);
      check($sformatf("gate_m3_trig%0d", i), int'(trig_m3),
            int'(exp_trig(wr, en_g, m3 == 3, 1'b1)));
      check($sformatf("gate_m0_count%0d", i), int'(cnt_m0), 0);
      check($sformatf("gate_m0_trig%0d", i), int'(trig_m0), int'(en_g));
      if (trig_m3) pulses++;
    end
    check("gate_m3_pulses", pulses, 4);
    en_g = 1'b0;

    // Width 12, MAX 4094: reaches 4094, wraps, never shows 4095.
    do_reset();
    en_big = 1'b1;
    saw_4094 = 1'b0;
    saw_4095 = 1'b0;
    pulses = 0;
    for (int i = 0; i < 4100; i++) begin
      step();
      if (cnt_big == 12'd4094) saw_4094 = 1'b1;
      if (cnt_big == 12'd4095) saw_4095 = 1'b1;
      if (trig_big) pulses++;
    end
    check("big_saw_4094", int'(saw_4094), 1);
    check("big_saw_4095", int'(saw_4095), 0);
    check("big_final_count", int'(cnt_big), 5);
    check("big_pulses", pulses, 1);
    en_big = 1'b0;

    // Cascade: A (MAX=3) strobe enables B (MAX=2); B strobes every 12 cycles.
    do_reset();
    en_c = 1'b1;
    pulses = 0;
    last = -1;
    for (int i = 1; i <= 50; i++) begin
      step();
      if (trig_b) begin
        if (last >= 0) check($sformatf("cascade_spacing%0d", pulses), i - last, 12);
        last = i;
        pulses++;
      end
    end
    check("cascade_pulses", pulses, 4);
    en_c = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
